// File: rtl/lcd_cmd_decoder.sv
// lcd_cmd_decoder: parses the SPI-LCD command/argument byte stream, keeps the
// window, MADCTL, COLMOD and display-state registers, and assembles RGB565 or
// RGB666 input pixels into a PIX_W-wide output (24 = RGB888, 16 = RGB565).
// Optional build macro LCDDEC_DCX_PIN_EN adds i_spi_dc for 4-wire D/CX framing;
// without it, command vs. data is inferred from the decoder state alone.
module lcd_cmd_decoder #(
    parameter int unsigned PIX_W    = 24,
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned MAX_ARGS = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [7:0]        i_spi_data,
    input  logic              i_spi_rxdone,
    input  logic              i_spi_csreleased,
`ifdef LCDDEC_DCX_PIN_EN
    input  logic              i_spi_dc,
`endif
    output logic [PIX_W-1:0]  o_pix_data,
    output logic              o_pix_valid,
    output logic              o_wr_start,
    output logic [ADDR_W-1:0] o_col_start,
    output logic [ADDR_W-1:0] o_col_end,
    output logic [ADDR_W-1:0] o_row_start,
    output logic [ADDR_W-1:0] o_row_end,
    output logic              o_waddr_set_req,
    output logic [7:0]        o_madctl,
    output logic              o_colmod_666,
    output logic              o_sram_clr_req,
    output logic              o_disp_on,
    output logic              o_invert
);

    localparam int unsigned CNT_W = (MAX_ARGS > 1) ? $clog2(MAX_ARGS) : 1;

    typedef enum logic [1:0] {ST_CMD, ST_ARGS, ST_PIX} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   rem_q, rem_d;       // argument bytes still expected, minus one
    logic [7:0]         op_q, op_d;
    logic [23:0]        sh_q, sh_d;         // last three argument bytes, oldest in [23:16]
    logic [1:0]         ph_q, ph_d;         // pixel byte phase
    logic [7:0]         pb0_q, pb0_d;
    logic [7:0]         pb1_q, pb1_d;
    logic               p666_q, p666_d;     // pixel format latched at RAMWR/RAMWRC

    logic [PIX_W-1:0]   pix_data_d;
    logic               pix_valid_d, wr_start_d, waddr_d, clr_d;
    logic [ADDR_W-1:0]  col_start_d, col_end_d, row_start_d, row_end_d;
    logic [7:0]         madctl_d;
    logic               colmod_d, disp_d, inv_d;

    logic               is_cmd, take;
    logic [4:0]         argc;
    logic [23:0]        rgb888;
    logic [15:0]        rgb565;
    logic [PIX_W-1:0]   pix_c;

    // Fixed argument count per opcode.
    function automatic logic [4:0] arg_count(input logic [7:0] op);
        case (op)
            8'h2A, 8'h2B:        arg_count = 5'd4;
            8'h36, 8'h3A, 8'h26: arg_count = 5'd1;
            8'hB1, 8'hB2, 8'hC0: arg_count = 5'd3;
            8'hB3:               arg_count = 5'd6;
            8'hE0, 8'hE1:        arg_count = 5'd16;
            default:             arg_count = 5'd0;
        endcase
    endfunction

    // Pixel formatting from the buffered bytes plus the byte arriving now.
    always_comb begin
        if (p666_q) begin
            rgb888 = {pb0_q[7:2], pb0_q[7:6], pb1_q[7:2], pb1_q[7:6],
                      i_spi_data[7:2], i_spi_data[7:6]};
            rgb565 = {pb0_q[7:3], pb1_q[7:2], i_spi_data[7:3]};
        end else begin
            rgb888 = {pb0_q[7:3], pb0_q[7:5], pb0_q[2:0], i_spi_data[7:5], pb0_q[2:1],
                      i_spi_data[4:0], i_spi_data[4:2]};
            rgb565 = {pb0_q, i_spi_data};
        end
        if (PIX_W == 16) pix_c = PIX_W'(rgb565);
        else             pix_c = PIX_W'(rgb888);
    end

    // Next-state and next-output decode.
    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        op_d        = op_q;
        sh_d        = sh_q;
        ph_d        = ph_q;
        pb0_d       = pb0_q;
        pb1_d       = pb1_q;
        p666_d      = p666_q;
        pix_data_d  = o_pix_data;
        pix_valid_d = 1'b0;
        wr_start_d  = 1'b0;
        waddr_d     = 1'b0;
        clr_d       = 1'b0;
        col_start_d = o_col_start;
        col_end_d   = o_col_end;
        row_start_d = o_row_start;
        row_end_d   = o_row_end;
        madctl_d    = o_madctl;
        colmod_d    = o_colmod_666;
        disp_d      = o_disp_on;
        inv_d       = o_invert;
        argc        = arg_count(i_spi_data);
`ifdef LCDDEC_DCX_PIN_EN
        is_cmd      = !i_spi_dc;
        take        = !(i_spi_dc && (state_q == ST_CMD));
`else
        is_cmd      = (state_q == ST_CMD);
        take        = 1'b1;
`endif

        if (i_spi_csreleased) begin
            state_d = ST_CMD;
            rem_d   = '0;
            ph_d    = '0;
        end else if (i_spi_rxdone && take) begin
            if (is_cmd) begin
                op_d    = i_spi_data;
                rem_d   = '0;
                ph_d    = '0;
                state_d = ST_CMD;
                case (i_spi_data)
                    8'h01: begin
                        clr_d    = 1'b1;
                        disp_d   = 1'b0;
                        madctl_d = 8'h00;
                        colmod_d = 1'b0;
                    end
                    8'h28:   disp_d     = 1'b0;
                    8'h29:   disp_d     = 1'b1;
                    8'h20:   inv_d      = 1'b0;
                    8'h21:   inv_d      = 1'b1;
                    8'h2C:   wr_start_d = 1'b1;
                    default: ;
                endcase
                if (i_spi_data == 8'h2C || i_spi_data == 8'h3C) begin
                    state_d = ST_PIX;
                    p666_d  = o_colmod_666;
                end else if (argc != 5'd0) begin
                    state_d = ST_ARGS;
                    if (32'(argc) > MAX_ARGS) rem_d = CNT_W'(MAX_ARGS - 1);
                    else                      rem_d = CNT_W'(argc - 5'd1);
                end
            end else if (state_q == ST_ARGS) begin
                sh_d = {sh_q[15:0], i_spi_data};
                case (op_q)
                    8'h36: madctl_d = i_spi_data;
                    8'h3A: begin
                        if (i_spi_data[2:0] == 3'b101)      colmod_d = 1'b0;
                        else if (i_spi_data[2:0] == 3'b110) colmod_d = 1'b1;
                    end
                    default: ;
                endcase
                if (rem_q == '0) begin
                    state_d = ST_CMD;
                    if (op_q == 8'h2A) begin
                        col_start_d = ADDR_W'(sh_q[23:8]);
                        col_end_d   = ADDR_W'({sh_q[7:0], i_spi_data});
                        waddr_d     = 1'b1;
                    end else if (op_q == 8'h2B) begin
                        row_start_d = ADDR_W'(sh_q[23:8]);
                        row_end_d   = ADDR_W'({sh_q[7:0], i_spi_data});
                        waddr_d     = 1'b1;
                    end
                end else begin
                    rem_d = rem_q - CNT_W'(1);
                end
            end else if (state_q == ST_PIX) begin
                if (ph_q == 2'd0) begin
                    pb0_d = i_spi_data;
                    ph_d  = 2'd1;
                end else if (ph_q == 2'd1 && p666_q) begin
                    pb1_d = i_spi_data;
                    ph_d  = 2'd2;
                end else begin
                    pix_data_d  = pix_c;
                    pix_valid_d = 1'b1;
                    ph_d        = 2'd0;
                end
            end
        end
    end

    // State and output registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q         <= ST_CMD;
            rem_q           <= '0;
            op_q            <= '0;
            sh_q            <= '0;
            ph_q            <= '0;
            pb0_q           <= '0;
            pb1_q           <= '0;
            p666_q          <= 1'b0;
            o_pix_data      <= '0;
            o_pix_valid     <= 1'b0;
            o_wr_start      <= 1'b0;
            o_col_start     <= '0;
            o_col_end       <= '0;
            o_row_start     <= '0;
            o_row_end       <= '0;
            o_waddr_set_req <= 1'b0;
            o_madctl        <= 8'h00;
            o_colmod_666    <= 1'b0;
            o_sram_clr_req  <= 1'b0;
            o_disp_on       <= 1'b0;
            o_invert        <= 1'b0;
        end else begin
            state_q         <= state_d;
            rem_q           <= rem_d;
            op_q            <= op_d;
            sh_q            <= sh_d;
            ph_q            <= ph_d;
            pb0_q           <= pb0_d;
            pb1_q           <= pb1_d;
            p666_q          <= p666_d;
            o_pix_data      <= pix_data_d;
            o_pix_valid     <= pix_valid_d;
            o_wr_start      <= wr_start_d;
            o_col_start     <= col_start_d;
            o_col_end       <= col_end_d;
            o_row_start     <= row_start_d;
            o_row_end       <= row_end_d;
            o_waddr_set_req <= waddr_d;
            o_madctl        <= madctl_d;
            o_colmod_666    <= colmod_d;
            o_sram_clr_req  <= clr_d;
            o_disp_on       <= disp_d;
            o_invert        <= inv_d;
        end
    end

endmodule

// File: tb/tb_lcd_cmd_decoder.sv
// Bench for lcd_cmd_decoder: directed byte streams followed by a random
// stream, both instances (RGB888 and RGB565 output) checked against a
// byte-level reference model of the command protocol.
`timescale 1ns/1ps
module tb_lcd_cmd_decoder;

    localparam int unsigned ADDR_W   = 16;
    localparam int unsigned MAX_ARGS = 16;
`ifdef LCDDEC_DCX_PIN_EN
    localparam bit DCX = 1'b1;
`else
    localparam bit DCX = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [7:0] spi_data = 8'h00;
    logic rxdone = 1'b0;
    logic csrel = 1'b0;
`ifdef LCDDEC_DCX_PIN_EN
    logic spi_dc = 1'b0;
`endif

    logic [23:0] pix24;
    logic [15:0] pix16;
    logic pv24, pv16, ws24, ws16, wq24, wq16, clr24, clr16;
    logic [ADDR_W-1:0] cs24, ce24, rs24, re24, cs16, ce16, rs16, re16;
    logic [7:0] md24, md16;
    logic c24, c16, don24, don16, inv24, inv16;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    lcd_cmd_decoder #(.PIX_W(24), .ADDR_W(ADDR_W), .MAX_ARGS(MAX_ARGS)) dut24 (
        .i_clk(clk), .i_rst_n(rst_n), .i_spi_data(spi_data), .i_spi_rxdone(rxdone),
        .i_spi_csreleased(csrel),
`ifdef LCDDEC_DCX_PIN_EN
        .i_spi_dc(spi_dc),
`endif
        .o_pix_data(pix24), .o_pix_valid(pv24), .o_wr_start(ws24),
        .o_col_start(cs24), .o_col_end(ce24), .o_row_start(rs24), .o_row_end(re24),
        .o_waddr_set_req(wq24), .o_madctl(md24), .o_colmod_666(c24),
        .o_sram_clr_req(clr24), .o_disp_on(don24), .o_invert(inv24));

    lcd_cmd_decoder #(.PIX_W(16), .ADDR_W(ADDR_W), .MAX_ARGS(MAX_ARGS)) dut16 (
        .i_clk(clk), .i_rst_n(rst_n), .i_spi_data(spi_data), .i_spi_rxdone(rxdone),
        .i_spi_csreleased(csrel),
`ifdef LCDDEC_DCX_PIN_EN
        .i_spi_dc(spi_dc),
`endif
        .o_pix_data(pix16), .o_pix_valid(pv16), .o_wr_start(ws16),
        .o_col_start(cs16), .o_col_end(ce16), .o_row_start(rs16), .o_row_end(re16),
        .o_waddr_set_req(wq16), .o_madctl(md16), .o_colmod_666(c16),
        .o_sram_clr_req(clr16), .o_disp_on(don16), .o_invert(inv16));

    // Reference model: protocol mode, collected argument/pixel bytes, registers.
    int          m_mode = 0;        // 0 command, 1 arguments, 2 pixel data
    logic [7:0]  m_op = 8'h00;
    int          m_need = 0;
    bit          m_p666 = 1'b0;
    logic [7:0]  m_args[$];
    logic [7:0]  m_pix[$];
    logic [15:0] e_cs = '0, e_ce = '0, e_rs = '0, e_re = '0;
    logic [7:0]  e_md = '0;
    bit          e_666 = 1'b0, e_don = 1'b0, e_inv = 1'b0;
    bit          e_pv = 1'b0, e_ws = 1'b0, e_wq = 1'b0, e_clr = 1'b0;
    logic [23:0] e_pix = '0;

    function automatic int argc(input logic [7:0] op);
        case (op)
            8'h2A, 8'h2B:        return 4;
            8'h36, 8'h3A, 8'h26: return 1;
            8'hB1, 8'hB2, 8'hC0: return 3;
            8'hB3:               return 6;
            8'hE0, 8'hE1:        return 16;
            default:             return 0;
        endcase
    endfunction

    task automatic clear_strobes();
        e_pv = 0; e_ws = 0; e_wq = 0; e_clr = 0;
    endtask

    task automatic model_cs();
        clear_strobes();
        m_mode = 0;
        m_args.delete();
        m_pix.delete();
    endtask

    task automatic model_byte(input logic [7:0] b, input bit dc);
        bit is_cmd;
        int r, g, bl, w;
        clear_strobes();
        if (DCX && dc && m_mode == 0) return;
        is_cmd = DCX ? !dc : (m_mode == 0);
        if (is_cmd) begin
            m_op = b;
            m_args.delete();
            m_pix.delete();
            case (b)
                8'h01: begin e_clr = 1; e_don = 0; e_md = 8'h00; e_666 = 0; end
                8'h28: e_don = 0;
                8'h29: e_don = 1;
                8'h20: e_inv = 0;
                8'h21: e_inv = 1;
                8'h2C: e_ws = 1;
                default: ;
            endcase
            if (b == 8'h2C || b == 8'h3C) begin
                m_mode = 2;
                m_p666 = e_666;
            end else begin
                m_need = (argc(b) > int'(MAX_ARGS)) ? int'(MAX_ARGS) : argc(b);
                m_mode = (m_need > 0) ? 1 : 0;
            end
        end else if (m_mode == 1) begin
            m_args.push_back(b);
            if (m_op == 8'h36) e_md = b;
            if (m_op == 8'h3A && (b % 8) == 5) e_666 = 0;
            if (m_op == 8'h3A && (b % 8) == 6) e_666 = 1;
            if (m_args.size() == m_need) begin
                if (m_op == 8'h2A) begin
                    e_cs = 16'(int'(m_args[0]) * 256 + int'(m_args[1]));
                    e_ce = 16'(int'(m_args[2]) * 256 + int'(m_args[3]));
                    e_wq = 1;
                end else if (m_op == 8'h2B) begin
                    e_rs = 16'(int'(m_args[0]) * 256 + int'(m_args[1]));
                    e_re = 16'(int'(m_args[2]) * 256 + int'(m_args[3]));
                    e_wq = 1;
                end
                m_mode = 0;
            end
        end else begin
            m_pix.push_back(b);
            if (m_pix.size() == (m_p666 ? 3 : 2)) begin
                if (m_p666) begin
                    r  = int'(m_pix[0]) / 4;
                    g  = int'(m_pix[1]) / 4;
                    bl = int'(m_pix[2]) / 4;
                    r  = r * 4 + r / 16;
                    g  = g * 4 + g / 16;
                    bl = bl * 4 + bl / 16;
                end else begin
                    w  = int'(m_pix[0]) * 256 + int'(m_pix[1]);
                    r  = w / 2048;
                    g  = (w / 32) % 64;
                    bl = w % 32;
                    r  = r * 8 + r / 4;
                    g  = g * 4 + g / 16;
                    bl = bl * 8 + bl / 4;
                end
                e_pix = 24'(r * 65536 + g * 256 + bl);
                e_pv  = 1;
                m_pix.delete();
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        int e565;
        e565 = (int'(e_pix[23:16]) / 8) * 2048 + (int'(e_pix[15:8]) / 4) * 32 + int'(e_pix[7:0]) / 8;
        chk("pix_valid24", 32'(pv24), 32'(e_pv));
        chk("pix_valid16", 32'(pv16), 32'(e_pv));
        chk("wr_start24", 32'(ws24), 32'(e_ws));
        chk("wr_start16", 32'(ws16), 32'(e_ws));
        chk("waddr_req24", 32'(wq24), 32'(e_wq));
        chk("waddr_req16", 32'(wq16), 32'(e_wq));
        chk("sram_clr24", 32'(clr24), 32'(e_clr));
        chk("sram_clr16", 32'(clr16), 32'(e_clr));
        if (e_pv) begin
            chk("pix_data24", 32'(pix24), 32'(e_pix));
            chk("pix_data16", 32'(pix16), 32'(e565));
        end
        chk("col_start", 32'(cs24), 32'(ADDR_W'(e_cs)));
        chk("col_end", 32'(ce24), 32'(ADDR_W'(e_ce)));
        chk("row_start", 32'(rs24), 32'(ADDR_W'(e_rs)));
        chk("row_end", 32'(re24), 32'(ADDR_W'(e_re)));
        chk("madctl", 32'(md24), 32'(e_md));
        chk("colmod_666", 32'(c24), 32'(e_666));
        chk("disp_on", 32'(don24), 32'(e_don));
        chk("invert", 32'(inv24), 32'(e_inv));
        chk("regs16", {cs16, ce16}, {ADDR_W'(e_cs), ADDR_W'(e_ce)});
        chk("regs16b", {rs16, re16}, {ADDR_W'(e_rs), ADDR_W'(e_re)});
        chk("regs16c", 32'({md16, c16, don16, inv16}), 32'({e_md, e_666, e_don, e_inv}));
    endtask

    // One byte (optionally coincident with CS release), then one idle cycle.
    task automatic send(input logic [7:0] b, input bit dc, input bit cs);
        @(negedge clk);
        spi_data = b;
        rxdone   = 1'b1;
        csrel    = cs;
`ifdef LCDDEC_DCX_PIN_EN
        spi_dc   = dc;
`endif
        @(posedge clk);
        @(negedge clk);
        rxdone = 1'b0;
        csrel  = 1'b0;
        if (cs) model_cs();
        else    model_byte(b, dc);
        check_all();
        @(negedge clk);
        clear_strobes();
        check_all();
    endtask

    task automatic cs_only();
        @(negedge clk);
        csrel = 1'b1;
        @(negedge clk);
        csrel = 1'b0;
        model_cs();
        check_all();
    endtask

    task automatic cmd(input logic [7:0] b);
        send(b, 1'b0, 1'b0);
    endtask

    task automatic dat(input logic [7:0] b);
        send(b, 1'b1, 1'b0);
    endtask

    logic [7:0] ops[19] = '{8'h01, 8'h20, 8'h21, 8'h28, 8'h29, 8'h2A, 8'h2B, 8'h2C, 8'h3C,
                           8'h36, 8'h3A, 8'h26, 8'hB1, 8'hB2, 8'hB3, 8'hC0, 8'hE0, 8'hE1, 8'h00};

    initial begin
        repeat (3) @(negedge clk);
        check_all();
        rst_n = 1'b1;
        @(negedge clk);
        check_all();

        // Window set
        cmd(8'h2A); dat(8'h00); dat(8'h10); dat(8'h00); dat(8'h9F);
        cmd(8'h2B); dat(8'h00); dat(8'h00); dat(8'h00); dat(8'h7F);

        // RGB565 pixel via RAMWR
        cmd(8'h3A); dat(8'h05);
        cmd(8'h2C); dat(8'hF8); dat(8'h00);
        dat(8'h07); dat(8'hE0);
        cs_only();

        // RGB666 pixel via RAMWRC, partial pixel discarded on CS release
        cmd(8'h3A); dat(8'h06);
        cmd(8'h3C); dat(8'hFC); dat(8'h00); dat(8'hFC);
        dat(8'h81); dat(8'h40);
        cs_only();
        cmd(8'h2C); dat(8'h55); dat(8'hAA); dat(8'h3C);
        cs_only();

        // Unsupported COLMOD value holds the format
        cmd(8'h3A); dat(8'h03);
        cmd(8'h3A); dat(8'hF5);

        // Aborted CASET, then display on
        cmd(8'h2A); dat(8'h00); dat(8'h05);
        cs_only();
        cmd(8'h29);

        // MADCTL, invert, software reset
        cmd(8'h36); dat(8'hC8);
        cmd(8'h21);
        cmd(8'h01);

        // Longest argument list, then a coincident byte/CS release is dropped
        cmd(8'hE0);
        for (int i = 0; i < 16; i++) dat(8'(i * 17));
        cmd(8'h29);
        send(8'h28, 1'b0, 1'b1);
        cmd(8'hB3); for (int i = 0; i < 6; i++) dat(8'h29);
        cmd(8'h20);

`ifdef LCDDEC_DCX_PIN_EN
        // D/CX framing: opcode aborts pixel and argument phases
        cmd(8'h28);
        cmd(8'h2C); dat(8'hF8); cmd(8'h29);
        cmd(8'h2A); dat(8'h01); dat(8'h02); cmd(8'h21);
        dat(8'h28);
        send(8'h28, 1'b0, 1'b1);
`endif

        // Random stream
        for (int i = 0; i < 600; i++) begin
            int r;
            logic [7:0] b;
            r = int'($urandom_range(0, 99));
            if (r < 4) begin
                cs_only();
            end else if (r < 7) begin
                send(8'($urandom), 1'b0, 1'b1);
            end else if (m_mode == 0 || (DCX && r < 15)) begin
                b = ops[$urandom_range(0, 18)];
                if (b == 8'h00) b = 8'($urandom);
                cmd(b);
            end else begin
                b = 8'($urandom);
                if (m_mode == 1 && m_op == 8'h3A && r < 70) b = (r < 40) ? 8'h05 : 8'h06;
                dat(b);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
